// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display drivers.
//   ssd_pix_t  : one displayed digit, packed as {dp, seg[6:0]} so it maps
//                straight onto an 8-bit segment port (bit 7 = decimal point).
//   SSD_OFF    : all segments and the decimal point dark, active-high view.
//   hex_to_ssd : hex nibble to active-low gfedcba pattern.
// ---------------------------------------------------------------------------
package ssd_pkg;

    typedef struct packed {
        logic       dp;
        logic [6:0] seg;
    } ssd_pix_t;

    localparam ssd_pix_t SSD_OFF = '{dp: 1'b0, seg: 7'b000_0000};

    // Active-low pattern, bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] hex_to_ssd(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b100_0000;
            4'h1:    pat = 7'b111_1001;
            4'h2:    pat = 7'b010_0100;
            4'h3:    pat = 7'b011_0000;
            4'h4:    pat = 7'b001_1001;
            4'h5:    pat = 7'b001_0010;
            4'h6:    pat = 7'b000_0010;
            4'h7:    pat = 7'b111_1000;
            4'h8:    pat = 7'b000_0000;
            4'h9:    pat = 7'b001_0000;
            4'hA:    pat = 7'b000_1000;
            4'hB:    pat = 7'b000_0011;
            4'hC:    pat = 7'b100_0110;
            4'hD:    pat = 7'b010_0001;
            4'hE:    pat = 7'b000_0110;
            default: pat = 7'b000_1110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// ---------------------------------------------------------------------------
// ssd_scan_timer
// Slot divider and unit index for multiplexed scanners (seven-segment
// displays, LED matrices).
//   clk, rst_n : clock, synchronous active-low reset
//   idx        : unit currently being scanned, 0..UNITS-1
//   frame_end  : last cycle of the last unit slot
//   blank      : inside the leading dark window of the current slot
// ---------------------------------------------------------------------------
module ssd_scan_timer #(
    parameter int UNITS    = 2,
    parameter int SCAN_DIV = 4096,
    parameter int BLANK    = 16,
    localparam int DIV_W   = $clog2(SCAN_DIV),
    localparam int IDX_W   = (UNITS > 1) ? $clog2(UNITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             frame_end,
    output logic             blank
);

    logic [DIV_W-1:0] div;
    logic             slot_end;

    assign slot_end  = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(UNITS - 1));
    assign blank     = (int'(div) < BLANK);

    // Divider runs continuously; the unit index steps once per slot and
    // wraps after the last unit (it never leaves 0 when UNITS is 1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (slot_end) begin
            div <= '0;
            if (idx == IDX_W'(UNITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
// Multiplexed seven-segment driver with a frame-aligned shadow buffer.
//   clk, rst_n : clock, synchronous active-low reset
//   in_value   : 4*DIGITS hex value, nibble i shown on digit i
//   in_dp      : per-digit decimal points, captured with in_value
//   in_valid   : update request; in_ready high when the shadow is empty
//   lz_en      : leading-zero blanking, applied live
//   seg        : registered {dp, g..a}, polarity set by SEG_ACTIVE_LOW
//   sel        : registered one-hot digit select, polarity by SEL_ACTIVE_LOW
//   frame_done : one-cycle pulse following the end of each frame
// ---------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int SCAN_DIV       = 4096,
    parameter int BLANK          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   in_value,
    input  logic [DIGITS-1:0]     in_dp,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  lz_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IDX_W-1:0]    idx;
    logic                frame_end;
    logic                blank;

    logic [4*DIGITS-1:0] shadow_value;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pending;
    logic [4*DIGITS-1:0] disp_value;
    logic [DIGITS-1:0]   disp_dp;

    logic                transfer;
    logic [3:0]          nib;
    logic                lz_blank;
    ssd_pix_t            pix;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   sel_onehot;
    logic [DIGITS-1:0]   sel_next;

    ssd_scan_timer #(
        .UNITS    (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .frame_end (frame_end),
        .blank     (blank)
    );

    assign in_ready = !pending;
    assign transfer = in_valid && in_ready;

    // A new value waits in the shadow until the end of a frame so a digit
    // scan never mixes old and new nibbles. A transfer can only coincide
    // with frame_end when the shadow is empty, so the commit and capture
    // branches are mutually exclusive and the new value waits a full frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            pending      <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
        end else begin
            if (frame_end && pending) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                pending    <= 1'b0;
            end
            if (transfer) begin
                shadow_value <= in_value;
                shadow_dp    <= in_dp;
                pending      <= 1'b1;
            end
        end
    end

    // Digit decode in an active-high view first; polarity is applied last.
    // A digit is leading-zero blanked when it and every digit above it are
    // zero, which the right shift by idx nibbles tests in one compare.
    always_comb begin
        nib        = disp_value[{idx, 2'b00} +: 4];
        lz_blank   = lz_en && (idx != '0) && ((disp_value >> {idx, 2'b00}) == '0);
        pix.seg    = ~hex_to_ssd(nib);
        pix.dp     = disp_dp[idx];
        if (blank || lz_blank) begin
            pix = SSD_OFF;
        end
        seg_next   = pix ^ {8{SEG_ACTIVE_LOW}};
        sel_onehot = '0;
        sel_onehot[idx] = !blank;
        sel_next   = sel_onehot ^ {DIGITS{SEL_ACTIVE_LOW}};
    end

    // Pin registers: one cycle behind the timer, dark and deselected in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= {8{SEG_ACTIVE_LOW}};
            sel        <= {DIGITS{SEL_ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            sel        <= sel_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
// Self-checking bench for ssd_scan_driver with DIGITS=4, SCAN_DIV=8, BLANK=2,
// active-low segments and active-high selects. Expected digit images are
// queued when a value is driven and consumed as frames appear on the pins.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_value = '0;
    logic [3:0]  in_dp = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        lz_en = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        frame_done;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    ssd_scan_driver #(
        .DIGITS         (DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .BLANK          (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_value   (in_value),
        .in_dp      (in_dp),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lz_en      (lz_en),
        .seg        (seg),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference glyphs, active-low gfedcba.
    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Pin image of one digit while lit, active-low segments and dp.
    function automatic logic [7:0] ref_digit(input logic [15:0] v, input logic [3:0] dp,
                                             input int i, input logic lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = i; j < DIGITS; j++) begin
            if (v[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        end
        if (lz && i != 0 && upper_zero) return 8'hFF;
        return {~dp[i], ref_glyph(v[4*i +: 4])};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        exp_t e;
        for (int i = 0; i < DIGITS; i++) begin
            e.sel = 4'b0001 << i;
            e.seg = ref_digit(v, dp, i, lz);
            sb.push_back(e);
        end
    endtask

    // Advances at least one cycle and stops on the negedge where frame_done is seen.
    task automatic wait_frame_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        checks++;
        if (frame_done !== 1'b1) $display("[TB] FAIL %s frame_done timeout: got %b after %0d cycles, expected 1", name, frame_done, n);
        else passed++;
    endtask

    // Called on a frame_done negedge; observes the next full frame digit by
    // digit against queued images and ends on the following frame_done.
    task automatic check_frame(input string name);
        exp_t       e;
        int         lit;
        int         dark;
        logic [3:0] bad_sel;
        logic [7:0] bad_seg;
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL %s digit %0d: scoreboard empty, expected a queued image", name, d);
                e.sel = 4'b0000;
                e.seg = 8'h00;
            end else begin
                passed++;
                e = sb.pop_front();
            end
            lit = 0;
            dark = 0;
            bad_sel = 4'b0000;
            bad_seg = 8'hFF;
            for (int c = 0; c < SCAN_DIV; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (sel === e.sel && seg === e.seg) lit++;
                else if (sel === 4'b0000 && seg === 8'hFF) dark++;
                else begin
                    bad_sel = sel;
                    bad_seg = seg;
                end
            end
            checks++;
            if (lit !== SCAN_DIV - BLANK) $display("[TB] FAIL %s digit %0d lit: got %0d cycles (stray sel=%b seg=%h), expected %0d cycles of sel=%b seg=%h",
                                                 name, d, lit, bad_sel, bad_seg, SCAN_DIV - BLANK, e.sel, e.seg);
            else passed++;
            checks++;
            if (dark !== BLANK) $display("[TB] FAIL %s digit %0d blank: got %0d cycles, expected %0d", name, d, dark, BLANK);
            else passed++;
        end
        checks++;
        if (frame_done !== 1'b1) $display("[TB] FAIL %s frame_period: frame_done got %b, expected 1", name, frame_done);
        else passed++;
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (seg !== 8'hFF) $display("[TB] FAIL reset_seg: got %h, expected ff", seg); else passed++;
        checks++;
        if (sel !== 4'b0000) $display("[TB] FAIL reset_sel: got %b, expected 0000", sel); else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b, expected 1", in_ready); else passed++;
        push_frame(16'h0000, 4'b0000, 1'b0);
        n = 0;
        while (sel === 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (sel !== e.sel) $display("[TB] FAIL reset_first_sel: got %b, expected %b", sel, e.sel); else passed++;
        checks++;
        if (seg !== e.seg) $display("[TB] FAIL reset_first_seg: got %h, expected %h", seg, e.seg); else passed++;
        sb.delete();
    endtask

    task automatic test_scan();
        wait_frame_done("scan_align");
        in_value = 16'h1234;
        in_dp    = 4'b0100;
        in_valid = 1'b1;
        push_frame(in_value, in_dp, lz_en);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL scan_ready_drop: got %b, expected 0", in_ready); else passed++;
        wait_frame_done("scan_commit");
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL scan_ready_rise: got %b, expected 1", in_ready); else passed++;
        check_frame("scan");
    endtask

    task automatic test_back_to_back();
        in_value = 16'hAAAA;
        in_dp    = 4'b0000;
        in_valid = 1'b1;
        push_frame(in_value, in_dp, lz_en);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_stall: in_ready got %b, expected 0", in_ready); else passed++;
        in_value = 16'hBBBB;
        push_frame(in_value, in_dp, lz_en);
        wait_frame_done("bp_commit");
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_commit: got %b, expected 1", in_ready); else passed++;
        check_frame("bp_first");
        check_frame("bp_second");
    endtask

    task automatic test_boundary();
        repeat (SCAN_DIV * DIGITS - 1) @(negedge clk);
        in_value = 16'h5678;
        in_dp    = 4'b0001;
        in_valid = 1'b1;
        push_frame(16'hBBBB, 4'b0000, lz_en);
        push_frame(in_value, in_dp, lz_en);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1) $display("[TB] FAIL boundary_align: frame_done got %b, expected 1", frame_done); else passed++;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL boundary_accept: in_ready got %b, expected 0", in_ready); else passed++;
        check_frame("boundary_old");
        check_frame("boundary_new");
    endtask

    task automatic test_lz();
        lz_en    = 1'b1;
        in_value = 16'h0050;
        in_dp    = 4'b0000;
        in_valid = 1'b1;
        push_frame(in_value, in_dp, lz_en);
        @(negedge clk);
        in_valid = 1'b0;
        wait_frame_done("lz_0050_commit");
        check_frame("lz_0050");
        in_value = 16'h0000;
        in_dp    = 4'b0010;
        in_valid = 1'b1;
        push_frame(in_value, in_dp, lz_en);
        @(negedge clk);
        in_valid = 1'b0;
        wait_frame_done("lz_0000_commit");
        check_frame("lz_0000");
        lz_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        in_value = 16'h9999;
        in_dp    = 4'b1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL mr_pending: in_ready got %b, expected 0", in_ready); else passed++;
        repeat (2 * SCAN_DIV + 3) @(negedge clk);
        checks++;
        if (sel !== 4'b0100 || seg !== 8'hC0) $display("[TB] FAIL mr_digit2: got sel=%b seg=%h, expected sel=0100 seg=c0", sel, seg); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (seg !== 8'hFF) $display("[TB] FAIL mr_seg: got %h, expected ff", seg); else passed++;
        checks++;
        if (sel !== 4'b0000) $display("[TB] FAIL mr_sel: got %b, expected 0000", sel); else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL mr_ready: got %b, expected 1", in_ready); else passed++;
        checks++;
        if (frame_done !== 1'b0) $display("[TB] FAIL mr_frame_done: got %b, expected 0", frame_done); else passed++;
        rst_n = 1'b1;
        push_frame(16'h0000, 4'b0000, lz_en);
        wait_frame_done("mr_align");
        check_frame("mr_zero");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_back_to_back();
        test_boundary();
        test_lz();
        test_mid_reset();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
